// File: rtl/onc_fetch_queue.sv
// Instruction prefetch queue: issues sequential fetches under a credit rule and buffers
// returned instructions with their addresses until decode accepts them.
module onc_fetch_queue #(
   parameter int          ADDR_W   = 16,
   parameter int          INST_W   = 16,
   parameter int          DEPTH    = 4,
   parameter int unsigned RESET_PC = 0
) (
   input  logic                       clock,
   input  logic                       n_rst,
   input  logic                       en,
   output logic [ADDR_W-1:0]          imem_addr,
   output logic                       imem_rd,
   input  logic [INST_W-1:0]          imem_din,
   input  logic                       br_en,
   input  logic [ADDR_W-1:0]          br_target,
   output logic [INST_W-1:0]          id_inst,
   output logic [ADDR_W-1:0]          id_pc,
   output logic                       id_valid,
   input  logic                       id_ready,
   output logic [$clog2(DEPTH):0]     q_count
);

   localparam int PW = $clog2(DEPTH);

   logic [ADDR_W-1:0] pc_reg;
   logic [ADDR_W-1:0] inflight_pc_reg;
   logic              inflight_reg;
   logic [PW-1:0]     wr_ptr_reg;
   logic [PW-1:0]     rd_ptr_reg;
   logic [PW:0]       count_reg;

   logic [INST_W-1:0] inst_mem [DEPTH];
   logic [ADDR_W-1:0] pc_mem   [DEPTH];

   logic              redirect;
   logic              issue;
   logic              push;
   logic              pop;
   logic [PW+1:0]     credit;

   // Occupancy plus the outstanding fetch; an issue is allowed only if its return has a free slot.
   assign credit   = {1'b0, count_reg} + {{(PW+1){1'b0}}, inflight_reg};
   assign redirect = en & br_en;
   assign issue    = n_rst & en & ~br_en & (credit < (PW+2)'(DEPTH));
   assign push     = inflight_reg & ~redirect;
   assign pop      = id_valid & id_ready & en & ~br_en;

   assign imem_addr = pc_reg;
   assign imem_rd   = issue;
   assign q_count   = count_reg;
   assign id_valid  = (count_reg != '0);
   assign id_inst   = id_valid ? inst_mem[rd_ptr_reg] : '0;
   assign id_pc     = id_valid ? pc_mem[rd_ptr_reg]   : '0;

   always_ff @(posedge clock or negedge n_rst) begin
      if (!n_rst) begin
         pc_reg          <= ADDR_W'(RESET_PC);
         inflight_pc_reg <= '0;
         inflight_reg    <= 1'b0;
         wr_ptr_reg      <= '0;
         rd_ptr_reg      <= '0;
         count_reg       <= '0;
      end else if (redirect) begin
         // Returning data for the old stream is dropped along with the queue.
         pc_reg       <= br_target;
         inflight_reg <= 1'b0;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
      end else begin
         if (issue) begin
            pc_reg          <= pc_reg + 1'b1;
            inflight_pc_reg <= pc_reg;
            inflight_reg    <= 1'b1;
         end else if (inflight_reg) begin
            inflight_reg <= 1'b0;
         end
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Entry storage needs no reset: occupancy gates every read.
   always_ff @(posedge clock) begin
      if (push) begin
         inst_mem[wr_ptr_reg] <= imem_din;
         pc_mem[wr_ptr_reg]   <= inflight_pc_reg;
      end
   end

endmodule

// File: tb/tb_onc_fetch_queue.sv
// Directed bench for onc_fetch_queue; memory returns addr+0x100, a monitor checks every decode pop.
module tb_onc_fetch_queue;

   logic        clock;
   logic        n_rst;
   logic        en;
   logic [15:0] imem_addr;
   logic        imem_rd;
   logic [15:0] imem_din;
   logic        br_en;
   logic [15:0] br_target;
   logic [15:0] id_inst;
   logic [15:0] id_pc;
   logic        id_valid;
   logic        id_ready;
   logic [2:0]  q_count;

   int n_cmp = 0;
   int n_bad = 0;
   logic [15:0] sb [$];

   onc_fetch_queue #(.ADDR_W(16), .INST_W(16), .DEPTH(4), .RESET_PC(0)) dut (
      .clock     (clock),
      .n_rst     (n_rst),
      .en        (en),
      .imem_addr (imem_addr),
      .imem_rd   (imem_rd),
      .imem_din  (imem_din),
      .br_en     (br_en),
      .br_target (br_target),
      .id_inst   (id_inst),
      .id_pc     (id_pc),
      .id_valid  (id_valid),
      .id_ready  (id_ready),
      .q_count   (q_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Instruction memory: data for the issued address appears one cycle later.
   initial imem_din = 16'h0000;
   always @(posedge clock) begin
      if (imem_rd) imem_din <= imem_addr + 16'h0100;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic expect_pc(input logic [15:0] pc);
      sb.push_back(pc);
   endtask

   // A pop happens on the next rising edge whenever these are true mid-cycle.
   always @(negedge clock) begin
      logic [15:0] exp_pc;
      if (n_rst && en && id_valid && id_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_pop", {16'h0, id_pc}, 32'hFFFF_FFFF);
         end else begin
            exp_pc = sb.pop_front();
            $display("pop pc=%04h inst=%04h (expected pc=%04h)", id_pc, id_inst, exp_pc);
            chk("pop_pc", {16'h0, id_pc}, {16'h0, exp_pc});
            chk("pop_inst", {16'h0, id_inst}, {16'h0, exp_pc + 16'h0100});
         end
      end
   end

   task automatic do_reset();
      id_ready = 1'b0;
      br_en    = 1'b0;
      en       = 1'b0;
      n_rst    = 1'b0;
      tick();
      tick();
      chk("sb_drained", sb.size(), 0);
      chk("rst_valid", id_valid, 0);
      chk("rst_count", q_count, 0);
      chk("rst_rd", imem_rd, 0);
      chk("rst_addr", imem_addr, 0);
      chk("rst_inst", id_inst, 0);
      chk("rst_pc", id_pc, 0);
   endtask

   initial begin
      n_rst = 1'b0; en = 1'b0; br_en = 1'b0; br_target = 16'h0; id_ready = 1'b0;

      // Streaming: one issue and one pop per cycle.
      do_reset();
      n_rst = 1'b1; en = 1'b1; id_ready = 1'b1;
      for (int p = 0; p < 4; p++) expect_pc(16'(p));
      @(negedge clock);
      chk("stream_addr0", imem_addr, 0);
      chk("stream_rd0", imem_rd, 1);
      for (int k = 1; k <= 5; k++) begin
         tick();
         @(negedge clock);
         chk("stream_addr", imem_addr, k);
         if (k == 1) chk("latency_not_yet", id_valid, 0);
         if (k == 2) chk("latency_visible", id_valid, 1);
      end
      tick();
      id_ready = 1'b0;

      // Backpressure: four pushes fill the queue, issue stops, then ordered drain.
      do_reset();
      n_rst = 1'b1; en = 1'b1;
      for (int p = 0; p < 4; p++) expect_pc(16'(p));
      tick(); tick(); tick(); tick();
      @(negedge clock);
      chk("credit_count3", q_count, 3);
      chk("credit_stop", imem_rd, 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         if (k == 2) id_ready = 1'b1;
         @(negedge clock);
         chk("full_count", q_count, 4);
         chk("full_rd", imem_rd, 0);
      end
      tick();
      @(negedge clock);
      chk("resume_count", q_count, 3);
      chk("resume_rd", imem_rd, 1);
      chk("resume_addr", imem_addr, 4);
      tick(); tick(); tick();
      id_ready = 1'b0;

      // Redirect with q_count=3 and a fetch in flight.
      do_reset();
      n_rst = 1'b1; en = 1'b1;
      tick(); tick(); tick(); tick();
      br_en = 1'b1; br_target = 16'h0040;
      @(negedge clock);
      chk("br_pre_count", q_count, 3);
      chk("br_no_issue", imem_rd, 0);
      tick();
      br_en = 1'b0; id_ready = 1'b1;
      expect_pc(16'h0040); expect_pc(16'h0041);
      @(negedge clock);
      chk("br_count", q_count, 0);
      chk("br_valid", id_valid, 0);
      chk("br_addr", imem_addr, 16'h0040);
      chk("br_rd", imem_rd, 1);
      tick(); tick();
      @(negedge clock);
      chk("br_first_valid", id_valid, 1);
      tick(); tick();
      id_ready = 1'b0;

      // Fetch PC wraps 0xFFFF -> 0x0000.
      do_reset();
      n_rst = 1'b1; en = 1'b1; id_ready = 1'b1; br_en = 1'b1; br_target = 16'hFFFE;
      expect_pc(16'hFFFE); expect_pc(16'hFFFF); expect_pc(16'h0000);
      @(negedge clock);
      chk("wrap_br_rd", imem_rd, 0);
      tick();
      br_en = 1'b0;
      @(negedge clock);
      chk("wrap_addr_fffe", imem_addr, 16'hFFFE);
      tick();
      @(negedge clock);
      chk("wrap_addr_ffff", imem_addr, 16'hFFFF);
      tick();
      @(negedge clock);
      chk("wrap_addr_0000", imem_addr, 16'h0000);
      tick(); tick(); tick();
      id_ready = 1'b0;

      // Enable low for three edges with a fetch in flight; redirect must be ignored.
      do_reset();
      n_rst = 1'b1; en = 1'b1; id_ready = 1'b1;
      expect_pc(16'h0000); expect_pc(16'h0001);
      tick();
      en = 1'b0; br_en = 1'b1; br_target = 16'h0077;
      @(negedge clock);
      chk("en0_rd", imem_rd, 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         if (k == 2) begin en = 1'b1; br_en = 1'b0; end
         @(negedge clock);
         chk("en0_count", q_count, 1);
         chk("en0_pc", id_pc, 0);
         chk("en0_addr", imem_addr, 1);
         if (k < 2) chk("en0_hold_rd", imem_rd, 0);
         else       chk("en1_resume_rd", imem_rd, 1);
      end
      tick(); tick(); tick();
      id_ready = 1'b0;

      // Asynchronous reset mid-run with q_count=2.
      do_reset();
      n_rst = 1'b1; en = 1'b1;
      tick(); tick(); tick();
      @(negedge clock);
      chk("arst_pre_count", q_count, 2);
      n_rst = 1'b0;
      #1;
      chk("arst_valid", id_valid, 0);
      chk("arst_count", q_count, 0);
      chk("arst_rd", imem_rd, 0);
      chk("arst_addr", imem_addr, 0);
      tick(); tick();
      n_rst = 1'b1; id_ready = 1'b1;
      expect_pc(16'h0000); expect_pc(16'h0001);
      @(negedge clock);
      chk("arst_first_addr", imem_addr, 0);
      chk("arst_first_rd", imem_rd, 1);
      tick(); tick(); tick(); tick();
      id_ready = 1'b0;
      tick();
      chk("sb_final_drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/onc_fetch_queue.md
ONC_FETCH_QUEUE -- requirements
Module: onc_fetch_queue

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, instruction address width (word-addressed).
REQ-002 SHALL have parameter INST_W, default 16, instruction width.
REQ-003 SHALL have parameter DEPTH, default 4, prefetch queue entries; power of two, >= 2.
REQ-004 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-005 SHALL have one clock and an asynchronous, active-low reset, with ports listed in the rows below.
REQ-006 SHALL have port: clock  input  1  sole clock, rising edge.
REQ-007 SHALL have port: n_rst  input  1  asynchronous active-low reset.
REQ-008 SHALL have port: en  input  1  global enable; low freezes PC, issue, pop and redirect.
REQ-009 SHALL have port: imem_addr  output  ADDR_W  fetch address (equals fetch PC).
REQ-010 SHALL have port: imem_rd  output  1  fetch issue strobe.
REQ-011 SHALL have port: imem_din  input  INST_W  instruction data, valid one cycle after issue.
REQ-012 SHALL have port: br_en  input  1  redirect request.
REQ-013 SHALL have port: br_target  input  ADDR_W  redirect address.
REQ-014 SHALL have port: id_inst  output  INST_W  queue head instruction.
REQ-015 SHALL have port: id_pc  output  ADDR_W  address of queue head instruction.
REQ-016 SHALL have port: id_valid  output  1  queue non-empty.
REQ-017 SHALL have port: id_ready  input  1  decode accepts head.
REQ-018 SHALL have port: q_count  output  clog2(DEPTH)+1  current occupancy.

Function
REQ-019 SHALL drive imem_addr combinationally from the fetch PC register.
REQ-020 SHALL assert imem_rd = en && !br_en && (q_count + inflight < DEPTH), where inflight is a 1-bit register marking an issued, unreturned fetch.
REQ-021 On an edge with imem_rd=1, SHALL set inflight=1, record the issued address as inflight PC, and advance fetch PC by 1, modulo 2^ADDR_W (0xFFFF -> 0x0000 at default width).
REQ-022 On an edge with inflight=1 and no redirect, SHALL push {imem_din, inflight PC} into the queue regardless of en, and clear inflight unless a new issue occurs on the same edge.
REQ-023 The credit rule in REQ-020 SHALL guarantee that a push never occurs when the queue is full; no overflow path exists.
REQ-024 SHALL present id_inst/id_pc from the queue head; id_valid = (q_count != 0); id_inst/id_pc are don't-care when id_valid=0.
REQ-025 SHALL pop on an edge where id_valid && id_ready && en; a pop with id_valid=0 has no effect.
REQ-026 On a simultaneous push and pop, q_count SHALL be unchanged and entry order SHALL be preserved.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH.
REQ-028 On an edge with br_en && en: fetch PC <= br_target, queue cleared (q_count=0), inflight cleared, and any returning imem_din discarded; no issue on that edge.
REQ-029 Redirect SHALL take priority over push and pop on the same edge; a head accepted on that edge is still treated as consumed by decode.
REQ-030 With en=0: fetch PC, queue contents and pointers SHALL hold except for the REQ-022 return push; br_en and id_ready SHALL be ignored.
REQ-031 Latency: an instruction issued at edge k SHALL be visible with id_valid=1 after edge k+1.
REQ-032 Steady state with id_ready=1 and en=1 SHALL sustain one instruction per cycle.

Reset
REQ-033 While n_rst=0: fetch PC=RESET_PC, inflight=0, q_count=0, id_valid=0, imem_rd driven low, pointers=0; id_inst/id_pc=0.
REQ-034 Reset asserted mid-operation SHALL discard queue and in-flight fetch immediately; the first issue after release SHALL be at RESET_PC.

Verification
REQ-035 Reset release, en=1, id_ready=1, memory returns addr+0x100 -> imem_addr 0,1,2,...; id_inst 0x100 with id_pc 0 one cycle after first issue, then one per cycle.
REQ-036 id_ready=0, DEPTH=4 -> exactly 4 pushes, imem_rd deasserts, q_count=4 holds; id_ready=1 -> ordered drain 0..3, issue resumes.
REQ-037 br_en=1, br_target=0x0040 while q_count=3 and inflight=1 -> q_count=0 next cycle, returning data dropped, next issue at 0x0040, first id_pc 0x0040.
REQ-038 Fetch PC at 0xFFFE (ADDR_W=16) -> issues 0xFFFE, 0xFFFF, 0x0000 with matching id_pc.
REQ-039 en=0 for 3 cycles with inflight=1 -> returning instruction pushed once, no issue, no pop, br_en ignored; state resumes unchanged when en=1.
REQ-040 n_rst pulsed low with q_count=2 -> id_valid=0, q_count=0 asynchronously; after release first issue at RESET_PC.
